// File: rtl/controller_poller.sv
// Polls two NES-style serial controllers on a frame or CPU trigger and
// commits both button bytes atomically for CPU readback.
//
// Ports:
//   clk_12_5875        system clock (only clock)
//   rst_B              async active-low reset
//   poll_start         one-cycle frame trigger
//   cpu_address        0 = player 1, 1 = player 2
//   data_in[7:0]       CPU write data (bit 0 requests a poll)
//   write_enable       CPU write strobe
//   SELECT_controller  address decode for this block
//   data_out[7:0]      read data, 0 when not selected for read
//   ctrl_latch         controller parallel-load strobe
//   ctrl_clk           controller shift clock, idles high
//   ctrl_data_1_B/2_B  serial button data, async, active-low
//   busy               poll in progress
//   poll_done          one-cycle pulse on commit
module controller_poller #(
    parameter int CLK_DIV      = 6,
    parameter int LATCH_CYCLES = 12
) (
    input  logic       clk_12_5875,
    input  logic       rst_B,
    input  logic       poll_start,
    input  logic       cpu_address,
    input  logic [7:0] data_in,
    input  logic       write_enable,
    input  logic       SELECT_controller,
    output logic [7:0] data_out,
    output logic       ctrl_latch,
    output logic       ctrl_clk,
    input  logic       ctrl_data_1_B,
    input  logic       ctrl_data_2_B,
    output logic       busy,
    output logic       poll_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] LAT_LAST = 8'(LATCH_CYCLES - 1);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] sync1_q, sync2_q;
    logic       req_q;
    logic [7:0] shadow1_q, shadow1_d;
    logic [7:0] shadow2_q, shadow2_d;
    logic [7:0] btn1_q, btn1_d;
    logic [7:0] btn2_q, btn2_d;

    logic req;
    logic trig;
    logic bit1;
    logic bit2;
    logic unused_data;

    assign unused_data = ^data_in[7:1];

    // One held CPU write yields a single trigger via edge detect.
    assign req  = SELECT_controller & write_enable & data_in[0];
    assign trig = poll_start | (req & ~req_q);

    // Wire is active-low; stored bits are active-high.
    assign bit1 = ~sync1_q[1];
    assign bit2 = ~sync2_q[1];

    assign ctrl_latch = (state_q == S_LATCH);
    assign ctrl_clk   = (state_q != S_PULSE);
    assign busy       = (state_q != S_IDLE);
    assign poll_done  = (state_q == S_DONE);

    always_comb begin
        data_out = 8'h00;
        if (SELECT_controller && !write_enable) begin
            data_out = cpu_address ? btn2_q : btn1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow1_d = shadow1_q;
        shadow2_d = shadow2_q;
        btn1_d    = btn1_q;
        btn2_d    = btn2_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_LATCH;
                    cnt_d   = 8'd0;
                end
            end
            S_LATCH: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = 8'd0;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d            = 8'd0;
                    shadow1_d[idx_q] = bit1;
                    shadow2_d[idx_q] = bit2;
                    if (idx_q == 3'd7) begin
                        // Both players commit on the same edge.
                        btn1_d  = {bit1, shadow1_q[6:0]};
                        btn2_d  = {bit2, shadow2_q[6:0]};
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = 8'd0;
                    idx_d   = idx_q + 3'd1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            idx_q     <= 3'd0;
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            req_q     <= 1'b0;
            shadow1_q <= 8'h00;
            shadow2_q <= 8'h00;
            btn1_q    <= 8'h00;
            btn2_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sync1_q   <= {sync1_q[0], ctrl_data_1_B};
            sync2_q   <= {sync2_q[0], ctrl_data_2_B};
            req_q     <= req;
            shadow1_q <= shadow1_d;
            shadow2_q <= shadow2_d;
            btn1_q    <= btn1_d;
            btn2_q    <= btn2_d;
        end
    end

endmodule
